// File: rtl/spi_frame_rd_if.sv
// Signal bundle between the frame reader (master) and the logic that requests frames and feeds sdi (slave).
// start is a level request sampled on every IDLE edge; done is a one-cycle completion pulse; rx_data is valid from done onward.
interface spi_frame_rd_if;
  logic         start;
  logic         abort;
  logic         sdi;
  logic         cs;
  logic         spiclk;
  logic         busy;
  logic         done;
  logic [127:0] rx_data;
  logic [31:0]  counter_h_T;
  logic [31:0]  counter_per_T;
  logic [31:0]  counter_per_duty;
  logic [31:0]  counter_duty;
  logic [15:0]  frame_cnt;
  logic [2:0]   dbg_state;

  modport master (
    input  start, abort, sdi,
    output cs, spiclk, busy, done, rx_data,
    output counter_h_T, counter_per_T, counter_per_duty, counter_duty,
    output frame_cnt, dbg_state
  );

  modport slave (
    output start, abort, sdi,
    input  cs, spiclk, busy, done, rx_data,
    input  counter_h_T, counter_per_T, counter_per_duty, counter_duty,
    input  frame_cnt, dbg_state
  );
endinterface

// File: rtl/spi_frame_rd.sv
// SPI master that reads one 128-bit frame (MSB first) from a counter slave per request
// and republishes it as four 32-bit counters once the frame completes.
module spi_frame_rd #(
  parameter int DIV      = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic          clk_50,
  input  logic          reset,
  spi_frame_rd_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_LOW   = 3'd2,
    S_HIGH  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LAST   = 8'(DIV - 1);
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);

  state_t       r_state, w_state;
  logic [7:0]   r_phase, w_phase;
  logic [6:0]   r_bit_cnt, w_bit_cnt;
  logic [127:0] r_shift, w_shift;
  logic [127:0] r_rx, w_rx;
  logic [15:0]  r_frame_cnt, w_frame_cnt;
  logic         r_cs, w_cs;
  logic         r_spiclk, w_spiclk;
  logic         r_busy, w_busy;
  logic         r_done, w_done;

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_rx        <= '0;
      r_frame_cnt <= '0;
      r_cs        <= 1'b1;
      r_spiclk    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_phase     <= w_phase;
      r_bit_cnt   <= w_bit_cnt;
      r_shift     <= w_shift;
      r_rx        <= w_rx;
      r_frame_cnt <= w_frame_cnt;
      r_cs        <= w_cs;
      r_spiclk    <= w_spiclk;
      r_busy      <= w_busy;
      r_done      <= w_done;
    end
  end

  // Every output is the registered copy of its next value, so spiclk cannot glitch.
  always_comb begin
    w_state     = r_state;
    w_phase     = r_phase + 8'd1;
    w_bit_cnt   = r_bit_cnt;
    w_shift     = r_shift;
    w_rx        = r_rx;
    w_frame_cnt = r_frame_cnt;
    w_cs        = r_cs;
    w_spiclk    = r_spiclk;
    w_busy      = r_busy;
    w_done      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_phase = '0;
        if (bus.start && !bus.abort) begin
          w_state   = S_SETUP;
          w_cs      = 1'b0;
          w_busy    = 1'b1;
          w_bit_cnt = '0;
        end
      end
      S_SETUP: begin
        if (r_phase == SETUP_LAST) begin
          w_state = S_LOW;
          w_phase = '0;
        end
      end
      S_LOW: begin
        if (r_phase == DIV_LAST) begin
          w_state  = S_HIGH;
          w_phase  = '0;
          w_spiclk = 1'b1;
          w_shift  = {r_shift[126:0], bus.sdi};
        end
      end
      S_HIGH: begin
        if (r_phase == DIV_LAST) begin
          w_phase   = '0;
          w_spiclk  = 1'b0;
          w_bit_cnt = r_bit_cnt + 7'd1;
          w_state   = (r_bit_cnt == 7'd127) ? S_HOLD : S_LOW;
        end
      end
      S_HOLD: begin
        if (r_phase == HOLD_LAST) begin
          w_state     = S_IDLE;
          w_phase     = '0;
          w_cs        = 1'b1;
          w_busy      = 1'b0;
          w_done      = 1'b1;
          w_rx        = r_shift;
          w_frame_cnt = r_frame_cnt + 16'd1;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_phase = '0;
      end
    endcase

    // Abort overrides whatever the active state decided, including a HOLD exit.
    if (r_state != S_IDLE && bus.abort) begin
      w_state     = S_IDLE;
      w_phase     = '0;
      w_bit_cnt   = '0;
      w_cs        = 1'b1;
      w_spiclk    = 1'b0;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      w_rx        = r_rx;
      w_frame_cnt = r_frame_cnt;
    end
  end

  assign bus.cs               = r_cs;
  assign bus.spiclk           = r_spiclk;
  assign bus.busy             = r_busy;
  assign bus.done             = r_done;
  assign bus.rx_data          = r_rx;
  assign bus.counter_h_T      = r_rx[31:0];
  assign bus.counter_per_T    = r_rx[63:32];
  assign bus.counter_per_duty = r_rx[95:64];
  assign bus.counter_duty     = r_rx[127:96];
  assign bus.frame_cnt        = r_frame_cnt;
  assign bus.dbg_state        = r_state;

endmodule

// File: tb/tb_spi_frame_rd.sv
// Bench for spi_frame_rd: a counter-slave model feeds queued words, a cycle monitor
// measures cs/spiclk/done timing, and a scoreboard checks each completed frame.
module tb_spi_frame_rd;
  localparam int DIV       = 2;
  localparam int CS_SETUP  = 2;
  localparam int CS_HOLD   = 2;
  localparam int FRAME_LOW = CS_SETUP + 256 * DIV + CS_HOLD;

  logic clk_50 = 1'b0;
  logic reset  = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   exp_frames = 0;

  logic [127:0] word_q[$];
  logic [127:0] exp_q[$];
  logic [127:0] got_q[$];
  logic [15:0]  fc_q[$];
  logic [127:0] last_word = '0;

  spi_frame_rd_if bus ();

  spi_frame_rd #(.DIV(DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
    .clk_50 (clk_50),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_50 = ~clk_50;

  // Counter slave: new word on each cs fall, next bit presented just after each spiclk rise.
  logic [127:0] cur_word = '0;
  int           bit_idx  = 0;
  always @(negedge bus.cs) begin
    if (word_q.size() > 0) cur_word = word_q.pop_front();
    else cur_word = '0;
    bit_idx = 0;
  end
  always @(posedge bus.spiclk) begin
    #1;
    bit_idx++;
  end
  assign bus.sdi = (bit_idx < 128) ? cur_word[7'(127 - bit_idx)] : 1'b0;

  // Monitor results of the most recent run_obs call.
  int o_cs_first, o_cs_last, o_cs_low, o_done_cnt, o_done_cyc, o_rises;
  int o_bad_hi, o_bad_lo, o_bad_hold, o_bad_busy, o_bad_rx, o_bad_done_len;
  int o_gap_cnt, o_gap_sum;

  // Cycle 0 raises start; cycle c is sampled at its falling edge. No comparisons here.
  task automatic run_obs(input bit rel, input int start_until, input int abort_at, input int max_c);
    logic prev_spk, prev_cs, prev_done;
    logic [127:0] prev_rx;
    int hi_run, lo_run, fr, cs_hi_run;
    o_cs_first = -1; o_cs_last = -1; o_cs_low = 0; o_done_cnt = 0; o_done_cyc = -1;
    o_rises = 0; o_bad_hi = 0; o_bad_lo = 0; o_bad_hold = 0; o_bad_busy = 0;
    o_bad_rx = 0; o_bad_done_len = 0; o_gap_cnt = 0; o_gap_sum = 0;
    hi_run = 0; lo_run = 0; fr = 0; cs_hi_run = 0;
    @(negedge clk_50);
    if (rel) reset = 1'b1;
    bus.start = 1'b1;
    bus.abort = (abort_at == 0);
    prev_spk = bus.spiclk; prev_cs = bus.cs; prev_done = bus.done; prev_rx = bus.rx_data;
    for (int c = 1; c <= max_c; c++) begin
      @(negedge clk_50);
      if (c == start_until) bus.start = 1'b0;
      bus.abort = (c == abort_at);
      if (!bus.cs && prev_cs) begin
        if (o_cs_first >= 0) begin o_gap_cnt++; o_gap_sum += cs_hi_run; end
        fr = 0; lo_run = 0;
      end
      if (!bus.cs) begin
        o_cs_low++;
        if (o_cs_first < 0) o_cs_first = c;
        o_cs_last = c;
        cs_hi_run = 0;
      end else cs_hi_run++;
      if (bus.busy !== ~bus.cs) o_bad_busy++;
      if (bus.done) begin
        o_done_cnt++; o_done_cyc = c;
        got_q.push_back(bus.rx_data); fc_q.push_back(bus.frame_cnt);
        if (prev_done) o_bad_done_len++;
      end else if (bus.rx_data !== prev_rx) o_bad_rx++;
      if (bus.spiclk && !prev_spk) begin
        o_rises++; fr++;
        if (lo_run != ((fr == 1) ? CS_SETUP + DIV : DIV)) o_bad_lo++;
        lo_run = 0; hi_run = 0;
      end
      if (bus.spiclk) hi_run++;
      if (!bus.spiclk && prev_spk && hi_run != DIV) o_bad_hi++;
      if (!bus.spiclk && !bus.cs) lo_run++;
      if (bus.cs && !prev_cs && bus.done && lo_run != CS_HOLD) o_bad_hold++;
      prev_spk = bus.spiclk; prev_cs = bus.cs; prev_done = bus.done; prev_rx = bus.rx_data;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_50);
    checks++; if (bus.cs !== 1'b1) begin failures++; $display("FAIL reset_cs got=%0b exp=1", bus.cs); end
    checks++; if (bus.spiclk !== 1'b0) begin failures++; $display("FAIL reset_spiclk got=%0b exp=0", bus.spiclk); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
    checks++; if (bus.rx_data !== 128'h0) begin failures++; $display("FAIL reset_rx got=%h exp=0", bus.rx_data); end
    checks++; if (bus.frame_cnt !== 16'h0) begin failures++; $display("FAIL reset_fcnt got=%h exp=0", bus.frame_cnt); end
    reset = 1'b1;
    repeat (2) @(negedge clk_50);
    checks++; if (bus.cs !== 1'b1 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset cs=%0b busy=%0b exp cs=1 busy=0", bus.cs, bus.busy);
    end
  endtask

  task automatic test_directed_frame();
    logic [127:0] w;
    logic [127:0] got;
    logic [15:0] fc;
    w = 128'h89ABCDEF_01234567_DEADBEEF_CAFEF00D;
    word_q.push_back(w); exp_q.push_back(w); last_word = w;
    run_obs(1'b0, 1, -1, 525);
    checks++; if (o_cs_first != 1) begin failures++; $display("FAIL dir_cs_first got=%0d exp=1", o_cs_first); end
    checks++; if (o_cs_last != 516) begin failures++; $display("FAIL dir_cs_last got=%0d exp=516", o_cs_last); end
    checks++; if (o_cs_low != FRAME_LOW) begin failures++; $display("FAIL dir_cs_low got=%0d exp=%0d", o_cs_low, FRAME_LOW); end
    checks++; if (o_done_cnt != 1 || o_done_cyc != 517) begin
      failures++; $display("FAIL dir_done cnt=%0d cyc=%0d exp cnt=1 cyc=517", o_done_cnt, o_done_cyc);
    end
    checks++; if (o_rises != 128) begin failures++; $display("FAIL dir_rises got=%0d exp=128", o_rises); end
    checks++; if (o_bad_hi != 0 || o_bad_lo != 0 || o_bad_hold != 0) begin
      failures++; $display("FAIL dir_spiclk_timing bad_hi=%0d bad_lo=%0d bad_hold=%0d exp all 0", o_bad_hi, o_bad_lo, o_bad_hold);
    end
    checks++; if (o_bad_busy != 0 || o_bad_done_len != 0) begin
      failures++; $display("FAIL dir_busy_done bad_busy=%0d bad_done_len=%0d exp 0", o_bad_busy, o_bad_done_len);
    end
    checks++; if (bus.counter_duty !== 32'h89ABCDEF) begin failures++; $display("FAIL dir_duty got=%h exp=89abcdef", bus.counter_duty); end
    checks++; if (bus.counter_per_duty !== 32'h01234567) begin failures++; $display("FAIL dir_per_duty got=%h exp=01234567", bus.counter_per_duty); end
    checks++; if (bus.counter_per_T !== 32'hDEADBEEF) begin failures++; $display("FAIL dir_per_T got=%h exp=deadbeef", bus.counter_per_T); end
    checks++; if (bus.counter_h_T !== 32'hCAFEF00D) begin failures++; $display("FAIL dir_h_T got=%h exp=cafef00d", bus.counter_h_T); end
    while (got_q.size() > 0) begin
      got = got_q.pop_front(); fc = fc_q.pop_front(); exp_frames++;
      checks++; if (exp_q.size() == 0 || got !== exp_q[0]) begin
        failures++; $display("FAIL dir_rx got=%h exp=%h", got, (exp_q.size() > 0) ? exp_q[0] : 128'h0);
      end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      checks++; if (fc !== 16'(exp_frames)) begin failures++; $display("FAIL dir_fcnt got=%h exp=%h", fc, 16'(exp_frames)); end
    end
  endtask

  task automatic test_random_frames();
    logic [127:0] w;
    logic [127:0] got;
    logic [15:0] fc;
    for (int n = 0; n < 4; n++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk_50);
      w = {$urandom, $urandom, $urandom, $urandom};
      word_q.push_back(w); exp_q.push_back(w); last_word = w;
      run_obs(1'b0, 1, -1, 522);
      checks++; if (o_cs_low != FRAME_LOW || o_rises != 128 || o_done_cnt != 1) begin
        failures++; $display("FAIL rnd_frame_shape n=%0d cs_low=%0d rises=%0d dones=%0d exp %0d/128/1", n, o_cs_low, o_rises, o_done_cnt, FRAME_LOW);
      end
      checks++; if (o_bad_hi + o_bad_lo + o_bad_hold + o_bad_rx + o_bad_busy != 0) begin
        failures++; $display("FAIL rnd_timing n=%0d hi=%0d lo=%0d hold=%0d rx=%0d busy=%0d exp all 0", n, o_bad_hi, o_bad_lo, o_bad_hold, o_bad_rx, o_bad_busy);
      end
      while (got_q.size() > 0) begin
        got = got_q.pop_front(); fc = fc_q.pop_front(); exp_frames++;
        checks++; if (exp_q.size() == 0 || got !== exp_q[0]) begin
          failures++; $display("FAIL rnd_rx n=%0d got=%h exp=%h", n, got, (exp_q.size() > 0) ? exp_q[0] : 128'h0);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        checks++; if (fc !== 16'(exp_frames)) begin failures++; $display("FAIL rnd_fcnt n=%0d got=%h exp=%h", n, fc, 16'(exp_frames)); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] w;
    logic [127:0] got;
    logic [15:0] fc;
    for (int n = 0; n < 3; n++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      word_q.push_back(w); exp_q.push_back(w); last_word = w;
    end
    run_obs(1'b0, 3 * (FRAME_LOW + 1), -1, 3 * (FRAME_LOW + 1) + 8);
    checks++; if (o_done_cnt != 3 || o_done_cyc != 3 * (FRAME_LOW + 1)) begin
      failures++; $display("FAIL b2b_done cnt=%0d last=%0d exp cnt=3 last=%0d", o_done_cnt, o_done_cyc, 3 * (FRAME_LOW + 1));
    end
    checks++; if (o_gap_cnt != 2 || o_gap_sum != 2) begin
      failures++; $display("FAIL b2b_gap gaps=%0d cs_high_cycles=%0d exp 2/2", o_gap_cnt, o_gap_sum);
    end
    checks++; if (o_cs_low != 3 * FRAME_LOW || o_rises != 384) begin
      failures++; $display("FAIL b2b_shape cs_low=%0d rises=%0d exp %0d/384", o_cs_low, o_rises, 3 * FRAME_LOW);
    end
    checks++; if (o_bad_hi + o_bad_lo + o_bad_hold + o_bad_rx + o_bad_done_len != 0) begin
      failures++; $display("FAIL b2b_timing hi=%0d lo=%0d hold=%0d rx=%0d dlen=%0d exp all 0", o_bad_hi, o_bad_lo, o_bad_hold, o_bad_rx, o_bad_done_len);
    end
    while (got_q.size() > 0) begin
      got = got_q.pop_front(); fc = fc_q.pop_front(); exp_frames++;
      checks++; if (exp_q.size() == 0 || got !== exp_q[0]) begin
        failures++; $display("FAIL b2b_rx got=%h exp=%h", got, (exp_q.size() > 0) ? exp_q[0] : 128'h0);
      end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      checks++; if (fc !== 16'(exp_frames)) begin failures++; $display("FAIL b2b_fcnt got=%h exp=%h", fc, 16'(exp_frames)); end
    end
  endtask

  task automatic test_abort();
    logic [127:0] w;
    logic [127:0] got;
    logic [15:0] fc;
    repeat (2) @(negedge clk_50);
    word_q.push_back({$urandom, $urandom, $urandom, $urandom});
    run_obs(1'b0, 1, 100, 110);
    checks++; if (o_cs_last != 100 || o_cs_low != 100) begin
      failures++; $display("FAIL abort_cs last=%0d low=%0d exp 100/100", o_cs_last, o_cs_low);
    end
    checks++; if (o_done_cnt != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", o_done_cnt); end
    checks++; if (o_bad_busy != 0 || bus.busy !== 1'b0 || bus.spiclk !== 1'b0) begin
      failures++; $display("FAIL abort_idle bad_busy=%0d busy=%0b spiclk=%0b exp 0/0/0", o_bad_busy, bus.busy, bus.spiclk);
    end
    checks++; if (bus.rx_data !== last_word) begin failures++; $display("FAIL abort_rx_kept got=%h exp=%h", bus.rx_data, last_word); end
    checks++; if (bus.frame_cnt !== 16'(exp_frames)) begin failures++; $display("FAIL abort_fcnt got=%h exp=%h", bus.frame_cnt, 16'(exp_frames)); end
    got_q.delete(); fc_q.delete();
    w = {$urandom, $urandom, $urandom, $urandom};
    word_q.push_back(w); exp_q.push_back(w); last_word = w;
    run_obs(1'b0, 1, -1, 522);
    checks++; if (o_done_cnt != 1 || o_done_cyc != FRAME_LOW + 1) begin
      failures++; $display("FAIL abort_next_done cnt=%0d cyc=%0d exp 1/%0d", o_done_cnt, o_done_cyc, FRAME_LOW + 1);
    end
    while (got_q.size() > 0) begin
      got = got_q.pop_front(); fc = fc_q.pop_front(); exp_frames++;
      checks++; if (exp_q.size() == 0 || got !== exp_q[0]) begin
        failures++; $display("FAIL abort_next_rx got=%h exp=%h", got, (exp_q.size() > 0) ? exp_q[0] : 128'h0);
      end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      checks++; if (fc !== 16'(exp_frames)) begin failures++; $display("FAIL abort_next_fcnt got=%h exp=%h", fc, 16'(exp_frames)); end
    end
  endtask

  task automatic test_abort_start_idle();
    run_obs(1'b0, 1, 0, 10);
    checks++; if (o_cs_low != 0 || o_done_cnt != 0 || o_bad_busy != 0) begin
      failures++; $display("FAIL abort_wins cs_low=%0d dones=%0d bad_busy=%0d exp all 0", o_cs_low, o_done_cnt, o_bad_busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [127:0] w;
    logic [127:0] got;
    logic [15:0] fc;
    bit seen;
    int cs_bad;
    word_q.push_back({$urandom, $urandom, $urandom, $urandom});
    @(negedge clk_50); bus.start = 1'b1;
    @(negedge clk_50); bus.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk_50);
      if (bus.spiclk === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL rst_wait_high got=no_spiclk_high exp=spiclk_high_within_40"); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.cs !== 1'b1 || bus.spiclk !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++; $display("FAIL rst_async_ctrl cs=%0b spiclk=%0b busy=%0b done=%0b exp 1/0/0/0", bus.cs, bus.spiclk, bus.busy, bus.done);
    end
    checks++; if (bus.rx_data !== 128'h0 || bus.frame_cnt !== 16'h0 || bus.counter_duty !== 32'h0) begin
      failures++; $display("FAIL rst_async_data rx=%h fcnt=%h exp 0/0", bus.rx_data, bus.frame_cnt);
    end
    exp_frames = 0;
    last_word = '0;
    // start held while reset is low must not open a frame
    cs_bad = 0;
    bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_50);
      if (bus.cs !== 1'b1) cs_bad++;
    end
    checks++; if (cs_bad != 0) begin failures++; $display("FAIL rst_start_blocked cs_low_cycles=%0d exp=0", cs_bad); end
    w = {$urandom, $urandom, $urandom, $urandom};
    word_q.push_back(w); exp_q.push_back(w); last_word = w;
    run_obs(1'b1, 1, -1, 522);
    checks++; if (o_cs_first != 1 || o_done_cnt != 1) begin
      failures++; $display("FAIL rst_first_start cs_first=%0d dones=%0d exp 1/1", o_cs_first, o_done_cnt);
    end
    while (got_q.size() > 0) begin
      got = got_q.pop_front(); fc = fc_q.pop_front(); exp_frames++;
      checks++; if (exp_q.size() == 0 || got !== exp_q[0]) begin
        failures++; $display("FAIL rst_rx got=%h exp=%h", got, (exp_q.size() > 0) ? exp_q[0] : 128'h0);
      end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      checks++; if (fc !== 16'(exp_frames)) begin failures++; $display("FAIL rst_fcnt got=%h exp=%h", fc, 16'(exp_frames)); end
    end
  endtask

  task automatic test_frame_cnt_wrap();
    logic [127:0] w;
    @(negedge clk_50);
    force dut.r_frame_cnt = 16'hFFFF;
    @(negedge clk_50);
    release dut.r_frame_cnt;
    exp_frames = 'hFFFF;
    w = {$urandom, $urandom, $urandom, $urandom};
    word_q.push_back(w); last_word = w;
    run_obs(1'b0, 1, -1, 522);
    exp_frames++;
    got_q.delete(); fc_q.delete();
    checks++; if (o_done_cnt != 1 || bus.frame_cnt !== 16'(exp_frames)) begin
      failures++; $display("FAIL wrap_fcnt dones=%0d got=%h exp=%h", o_done_cnt, bus.frame_cnt, 16'(exp_frames));
    end
    checks++; if (bus.rx_data !== w) begin failures++; $display("FAIL wrap_rx got=%h exp=%h", bus.rx_data, w); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    test_reset();
    test_directed_frame();
    test_random_frames();
    test_back_to_back();
    test_abort();
    test_abort_start_idle();
    test_reset_mid_frame();
    test_frame_cnt_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
